// File: rtl/stm_adder_nbit_gen.sv
// stm_adder_nbit_gen
// Clocked stimulus generator for N-bit adders. It issues (A, B, Cin) vectors
// in random, exhaustive, walking-one or corner mode, using a valid/ready
// handshake. Each run has a fixed vector budget, can be aborted, and ends
// with a one-cycle done pulse.
// All outputs are registered. The next vector is computed combinationally
// and captured on the same edge that accepts the current one.
module stm_adder_nbit_gen #(
  parameter int          WIDTH       = 8,
  parameter int          NUM_VECTORS = 256,
  parameter logic [31:0] SEED        = 32'h0000_0001
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               stop,
  input  logic [1:0]                         mode,
  input  logic                               ready,
  output logic [WIDTH-1:0]                   a_out,
  output logic [WIDTH-1:0]                   b_out,
  output logic                               cin_out,
  output logic                               valid,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(NUM_VECTORS+1)-1:0]   vec_count
);

  localparam int          VW       = 2 * WIDTH + 1;
  localparam int          CW       = $clog2(NUM_VECTORS + 1);
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0000_0000) ? 32'h0000_0001 : SEED;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [31:0]     lfsr_r, lfsr_s;
  logic [VW-1:0]   exh_r, exh_s;
  logic [1:0]      mode_r, mode_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [CW-1:0]   cnt_inc_s;
  logic            last_s;
  logic [VW-1:0]   vec_r, vec_s;
  logic            valid_r, valid_s;
  logic            busy_r, busy_s;
  logic            done_r, done_s;

  // One step of the 32-bit Galois LFSR (taps 32'h8020_0003).
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    lfsr_step = {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0000_0000);
  endfunction

  // Builds the {cin, b, a} vector for a mode from the generator state that
  // applies to the vector being presented.
  function automatic logic [VW-1:0] make_vec(
    input logic [1:0]    m,
    input logic [VW-1:0] lfsr_bits,
    input logic [VW-1:0] exh,
    input logic [CW-1:0] cnt
  );
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] zero;
    logic [WIDTH-1:0] walk;
    logic [31:0]      cnt32;
    logic [31:0]      widx;
    ones  = '1;
    zero  = '0;
    cnt32 = 32'(cnt);
    widx  = cnt32 % 32'(WIDTH);
    for (int k = 0; k < WIDTH; k++) begin
      walk[k] = (32'(k) == widx);
    end
    case (m)
      2'd0: make_vec = lfsr_bits;
      2'd1: make_vec = exh;
      2'd2: make_vec = {1'b1, ~walk, walk};
      2'd3: begin
        case (cnt32[1:0])
          2'd0:    make_vec = {1'b0, zero, zero};
          2'd1:    make_vec = {1'b1, ones, ones};
          2'd2:    make_vec = {1'b1, zero, ones};
          2'd3:    make_vec = {1'b0, ones, zero};
          default: make_vec = '0;
        endcase
      end
      default: make_vec = '0;
    endcase
  endfunction

  // Accept bookkeeping: the incremented count and whether this accept ends the run.
  always_comb begin
    cnt_inc_s = cnt_r + CW'(1);
    if (cnt_inc_s == CW'(NUM_VECTORS)) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic. In RUN, stop takes priority over an accept.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_s = ST_IDLE;
        end else if (ready && last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Output and datapath next values. The vector registered here is the one
  // presented in the following cycle.
  always_comb begin
    lfsr_s  = lfsr_r;
    exh_s   = exh_r;
    mode_s  = mode_r;
    cnt_s   = cnt_r;
    vec_s   = vec_r;
    valid_s = valid_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          mode_s  = mode;
          cnt_s   = '0;
          lfsr_s  = SEED_EFF;
          exh_s   = '0;
          vec_s   = make_vec(mode, SEED_EFF[VW-1:0], '0, '0);
          valid_s = 1'b1;
          busy_s  = 1'b1;
        end else begin
          valid_s = 1'b0;
          busy_s  = 1'b0;
        end
      end
      ST_RUN: begin
        if (stop) begin
          vec_s   = '0;
          valid_s = 1'b0;
          busy_s  = 1'b0;
        end else if (ready) begin
          cnt_s  = cnt_inc_s;
          lfsr_s = lfsr_step(lfsr_r);
          exh_s  = exh_r + VW'(1);
          if (last_s) begin
            vec_s   = '0;
            valid_s = 1'b0;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else begin
            vec_s   = make_vec(mode_r, lfsr_s[VW-1:0], exh_s, cnt_inc_s);
            valid_s = 1'b1;
            busy_s  = 1'b1;
          end
        end else begin
          valid_s = 1'b1;
          busy_s  = 1'b1;
        end
      end
      ST_DONE: begin
        vec_s   = '0;
        valid_s = 1'b0;
        busy_s  = 1'b0;
      end
      default: begin
        vec_s   = '0;
        valid_s = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r  <= SEED_EFF;
      exh_r   <= '0;
      mode_r  <= 2'd0;
      cnt_r   <= '0;
      vec_r   <= '0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      lfsr_r  <= lfsr_s;
      exh_r   <= exh_s;
      mode_r  <= mode_s;
      cnt_r   <= cnt_s;
      vec_r   <= vec_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign a_out     = vec_r[WIDTH-1:0];
  assign b_out     = vec_r[2*WIDTH-1:WIDTH];
  assign cin_out   = vec_r[2*WIDTH];
  assign valid     = valid_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign vec_count = cnt_r;

endmodule

// File: tb/tb_stm_adder_nbit_gen.sv
// Directed testbench for stm_adder_nbit_gen. Three instances with different
// parameters share the clock, reset, stop, mode and ready signals. Each
// instance has its own start, so only one of them runs at a time.
module tb_stm_adder_nbit_gen;

  logic clk;
  logic rst_n;
  logic stop;
  logic [1:0] mode;
  logic ready;
  logic start8, start2, start4;

  logic [7:0] a8, b8;
  logic       cin8, valid8, busy8, done8;
  logic [1:0] cnt8;
  logic [1:0] a2, b2;
  logic       cin2, valid2, busy2, done2;
  logic [5:0] cnt2;
  logic [3:0] a4, b4;
  logic       cin4, valid4, busy4, done4;
  logic [2:0] cnt4;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  stm_adder_nbit_gen #(.WIDTH(8), .NUM_VECTORS(2), .SEED(32'h0000_0001)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .stop(stop), .mode(mode), .ready(ready),
    .a_out(a8), .b_out(b8), .cin_out(cin8), .valid(valid8), .busy(busy8),
    .done(done8), .vec_count(cnt8));

  stm_adder_nbit_gen #(.WIDTH(2), .NUM_VECTORS(32), .SEED(32'h0000_0001)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .stop(stop), .mode(mode), .ready(ready),
    .a_out(a2), .b_out(b2), .cin_out(cin2), .valid(valid2), .busy(busy2),
    .done(done2), .vec_count(cnt2));

  stm_adder_nbit_gen #(.WIDTH(4), .NUM_VECTORS(5), .SEED(32'h0000_0001)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .stop(stop), .mode(mode), .ready(ready),
    .a_out(a4), .b_out(b4), .cin_out(cin4), .valid(valid4), .busy(busy4),
    .done(done4), .vec_count(cnt4));

  // Free-running clock with a 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] walk_a [5];
    logic [3:0] walk_b [5];
    walk_a = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    walk_b = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};

    rst_n = 1'b0; stop = 1'b0; mode = 2'd0; ready = 1'b0;
    start8 = 1'b0; start2 = 1'b0; start4 = 1'b0;
    #1;
    check("rst_vec8", {cin8, b8, a8}, 32'h0);
    check("rst_ctl8", {valid8, busy8, done8}, 32'h0);
    check("rst_cnt8", cnt8, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    // Random mode, two-vector budget
    mode = 2'd0; ready = 1'b1; start8 = 1'b1;
    step();
    start8 = 1'b0;
    check("rnd_v1", {cin8, b8, a8}, {15'h0, 1'b0, 8'h00, 8'h01});
    check("rnd_vb1", {valid8, busy8}, 32'h3);
    step();
    check("rnd_v2", {cin8, b8, a8}, {15'h0, 1'b0, 8'h00, 8'h03});
    check("rnd_cnt1", cnt8, 32'd1);
    step();
    check("rnd_done", {valid8, busy8, done8}, 32'h1);
    check("rnd_cnt2", cnt8, 32'd2);
    check("rnd_zero", {cin8, b8, a8}, 32'h0);
    step();
    check("rnd_done_drop", done8, 32'h0);
    check("rnd_cnt_hold", cnt8, 32'd2);

    // Exhaustive mode, WIDTH=2: all 32 combinations in order
    mode = 2'd1; ready = 1'b1; start2 = 1'b1;
    step();
    start2 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      check("exh_vec", {cin2, b2, a2}, 32'(i));
      check("exh_valid", valid2, 32'h1);
      step();
    end
    check("exh_done", {valid2, done2}, 32'h1);
    check("exh_cnt", cnt2, 32'd32);
    step();
    check("exh_done_drop", done2, 32'h0);

    // Backpressure in exhaustive mode
    ready = 1'b0; start2 = 1'b1;
    step();
    start2 = 1'b0;
    check("bp_cnt_clear", cnt2, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_vec", {valid2, cin2, b2, a2}, 32'h20);
      check("bp_hold_cnt", cnt2, 32'd0);
    end
    ready = 1'b1;
    step();
    check("bp_accept_cnt", cnt2, 32'd1);
    check("bp_next_vec", {cin2, b2, a2}, 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("bp_stop", {valid2, busy2, done2}, 32'h0);
    check("bp_stop_cnt", cnt2, 32'd1);

    // Walking-one mode, WIDTH=4, five vectors
    mode = 2'd2; ready = 1'b1; start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("walk_a", a4, 32'(walk_a[i]));
      check("walk_b", b4, 32'(walk_b[i]));
      check("walk_cin", {valid4, cin4}, 32'h3);
      step();
    end
    check("walk_done", done4, 32'h1);
    check("walk_cnt", cnt4, 32'd5);
    step();

    // Corner mode with stop after three accepts
    mode = 2'd3; ready = 1'b1; start4 = 1'b1;
    step();
    start4 = 1'b0;
    check("cor_i0", {cin4, b4, a4}, {1'b0, 4'h0, 4'h0});
    step();
    check("cor_i1", {cin4, b4, a4}, {1'b1, 4'hF, 4'hF});
    step();
    check("cor_i2", {cin4, b4, a4}, {1'b1, 4'h0, 4'hF});
    step();
    check("cor_i3", {cin4, b4, a4}, {1'b0, 4'hF, 4'h0});
    check("cor_cnt3", cnt4, 32'd3);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("cor_stop", {valid4, busy4, done4}, 32'h0);
    check("cor_stop_cnt", cnt4, 32'd3);
    step();
    check("cor_no_done", done4, 32'h0);
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    check("cor_restart", {valid4, cin4, b4, a4}, {1'b1, 1'b0, 4'h0, 4'h0});
    check("cor_restart_cnt", cnt4, 32'd0);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // Asynchronous reset in the middle of a run, then restart
    mode = 2'd0; ready = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step();
    check("mid_run_valid", {valid8, busy8}, 32'h3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_vec", {cin8, b8, a8}, 32'h0);
    check("async_rst_ctl", {valid8, busy8, done8}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ready = 1'b1; start8 = 1'b1;
    step();
    start8 = 1'b0;
    check("rst_rnd_v1", {cin8, b8, a8}, {15'h0, 1'b0, 8'h00, 8'h01});
    step();
    check("rst_rnd_v2", {cin8, b8, a8}, {15'h0, 1'b0, 8'h00, 8'h03});
    step();
    check("rst_rnd_done", {done8, cnt8}, {29'h0, 1'b1, 2'd2});

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
